clock_gen_ctrl: RTL and testbench

CLOCK_GEN_CTRL -- requirements
Module: clock_gen_ctrl

---
 rtl/clock_gen_ctrl_if.sv | 13 +
 rtl/clock_gen_ctrl.sv | 150 +++++++++++++++
 tb/tb_clock_gen_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/clock_gen_ctrl_if.sv
// Configuration channel for clock_gen_ctrl: valid/ready handshake carrying high, low and phase counts.
interface clock_gen_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_high;
  logic [CNT_W-1:0] cfg_low;
  logic [CNT_W-1:0] cfg_phase;

  modport master (output cfg_valid, cfg_high, cfg_low, cfg_phase, input cfg_ready);
  modport slave  (input cfg_valid, cfg_high, cfg_low, cfg_phase, output cfg_ready);
endinterface

// File: rtl/clock_gen_ctrl.sv
// Programmable divided-clock generator with start delay; outputs registered, clk_out rises phase+1 cycles after enable.
// Config accepted whenever the single pending slot is empty; a queued config takes effect at the next period boundary.
module clock_gen_ctrl #(
  parameter int CNT_W    = 16,
  parameter int RST_HIGH = 1,
  parameter int RST_LOW  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  clock_gen_ctrl_if.slave      cfg,
  output logic                 clk_out,
  output logic                 running,
  output logic                 period_tick,
  output logic                 cfg_err
);

  typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} state_e;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
  localparam logic [CNT_W-1:0] RST_HI_V = CNT_W'(RST_HIGH);
  localparam logic [CNT_W-1:0] RST_LO_V = CNT_W'(RST_LOW);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] act_high_q, act_low_q, act_phase_q;
  logic [CNT_W-1:0] pend_high_q, pend_low_q, pend_phase_q;
  logic             pend_full_q;
  logic             clk_out_q, running_q, period_tick_q, cfg_err_q;

  logic             xfer, cfg_bad, xfer_ok, idle_load;
  logic [CNT_W-1:0] high_d, phase_d, next_high_d;

  assign cfg.cfg_ready = ~pend_full_q;
  assign xfer          = cfg.cfg_valid & ~pend_full_q;
  assign cfg_bad       = (cfg.cfg_high == '0) || (cfg.cfg_low == '0);
  assign xfer_ok       = xfer & ~cfg_bad;
  assign idle_load     = xfer_ok && (state_q == IDLE);

  // An IDLE transfer is visible to the start decision in the same cycle.
  assign high_d      = idle_load ? cfg.cfg_high  : act_high_q;
  assign phase_d     = idle_load ? cfg.cfg_phase : act_phase_q;
  assign next_high_d = pend_full_q ? pend_high_q : act_high_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      act_high_q    <= RST_HI_V;
      act_low_q     <= RST_LO_V;
      act_phase_q   <= '0;
      pend_high_q   <= '0;
      pend_low_q    <= '0;
      pend_phase_q  <= '0;
      pend_full_q   <= 1'b0;
      clk_out_q     <= 1'b0;
      running_q     <= 1'b0;
      period_tick_q <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      cfg_err_q     <= xfer & cfg_bad;
      period_tick_q <= 1'b0;

      if (xfer_ok) begin
        if (state_q == IDLE) begin
          act_high_q  <= cfg.cfg_high;
          act_low_q   <= cfg.cfg_low;
          act_phase_q <= cfg.cfg_phase;
        end else begin
          pend_high_q  <= cfg.cfg_high;
          pend_low_q   <= cfg.cfg_low;
          pend_phase_q <= cfg.cfg_phase;
          pend_full_q  <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (enable) begin
            running_q <= 1'b1;
            if (phase_d != '0) begin
              state_q <= DELAY;
              cnt_q   <= phase_d;
            end else begin
              state_q   <= HIGH;
              cnt_q     <= high_d;
              clk_out_q <= 1'b1;
            end
          end
        end
        DELAY: begin
          if (!enable) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
          end else if (cnt_q == ONE) begin
            state_q   <= HIGH;
            cnt_q     <= act_high_q;
            clk_out_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
        HIGH: begin
          if (cnt_q == ONE) begin
            state_q       <= LOW;
            cnt_q         <= act_low_q;
            clk_out_q     <= 1'b0;
            period_tick_q <= (act_low_q == ONE);
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
        LOW: begin
          if (cnt_q == ONE) begin
            // Period boundary: promote the queued config; the start delay is not re-applied.
            if (pend_full_q) begin
              act_high_q  <= pend_high_q;
              act_low_q   <= pend_low_q;
              act_phase_q <= pend_phase_q;
              pend_full_q <= 1'b0;
            end
            if (enable) begin
              state_q   <= HIGH;
              cnt_q     <= next_high_d;
              clk_out_q <= 1'b1;
            end else begin
              state_q   <= IDLE;
              running_q <= 1'b0;
            end
          end else begin
            cnt_q         <= cnt_q - ONE;
            period_tick_q <= (cnt_q == TWO);
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
          clk_out_q <= 1'b0;
        end
      endcase
    end
  end

  assign clk_out     = clk_out_q;
  assign running     = running_q;
  assign period_tick = period_tick_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_clock_gen_ctrl.sv
// Bench for clock_gen_ctrl: period-arithmetic reference model checked every cycle, plus directed literal checks.
module tb_clock_gen_ctrl;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst, enable;
  logic clk_out, running, period_tick, cfg_err;

  clock_gen_ctrl_if #(.CNT_W(W)) cfg_if ();

  clock_gen_ctrl #(.CNT_W(W), .RST_HIGH(1), .RST_LOW(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .cfg        (cfg_if),
    .clk_out    (clk_out),
    .running    (running),
    .period_tick(period_tick),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a period is a window starting at m_start; HIGH covers the first m_hi
  // cycles, LOW the next m_lo, and the tick lands on the window's last cycle.
  int   cyc = 0;
  bit   m_on = 0;
  int   m_mode;               // 0 idle, 1 waiting for start, 2 running periods
  int   m_start, m_hi, m_lo;
  int   ah, al, ap;
  bit   pv;
  int   ph, pl, pp;
  logic e_clk, e_run, e_tick, e_err, e_rdy;

  always @(posedge clk) begin
    bit xfer, bad;
    cyc++;
    if (rst) begin
      m_on = 1; m_mode = 0;
      ah = 1; al = 1; ap = 0; pv = 0;
      e_err = 0;
    end else if (m_on) begin
      xfer  = cfg_if.cfg_valid && !pv;
      bad   = (cfg_if.cfg_high == 0) || (cfg_if.cfg_low == 0);
      e_err = xfer && bad;
      case (m_mode)
        0: begin
          if (xfer && !bad) begin
            ah = int'(cfg_if.cfg_high); al = int'(cfg_if.cfg_low); ap = int'(cfg_if.cfg_phase);
          end
          if (enable) begin
            if (ap > 0) begin m_mode = 1; m_start = cyc + ap; end
            else begin m_mode = 2; m_start = cyc; m_hi = ah; m_lo = al; end
          end
        end
        1: begin
          if (xfer && !bad) begin
            pv = 1; ph = int'(cfg_if.cfg_high); pl = int'(cfg_if.cfg_low); pp = int'(cfg_if.cfg_phase);
          end
          if (!enable) m_mode = 0;
          else if (cyc == m_start) begin m_mode = 2; m_hi = ah; m_lo = al; end
        end
        default: begin
          if (cyc - 1 - m_start == m_hi + m_lo - 1) begin
            if (pv) begin ah = ph; al = pl; ap = pp; pv = 0; end
            if (enable) begin m_start = cyc; m_hi = ah; m_lo = al; end
            else m_mode = 0;
          end
          if (xfer && !bad) begin
            pv = 1; ph = int'(cfg_if.cfg_high); pl = int'(cfg_if.cfg_low); pp = int'(cfg_if.cfg_phase);
          end
        end
      endcase
    end
    if (m_on) begin
      e_rdy  = !pv;
      e_run  = (m_mode != 0);
      e_clk  = (m_mode == 2) && (cyc - m_start < m_hi);
      e_tick = (m_mode == 2) && (cyc - m_start == m_hi + m_lo - 1);
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("model clk_out",     clk_out,          e_clk);
      chk("model running",     running,          e_run);
      chk("model period_tick", period_tick,      e_tick);
      chk("model cfg_err",     cfg_err,          e_err);
      chk("model cfg_ready",   cfg_if.cfg_ready, e_rdy);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_clk_high(input int budget, input string nm);
    int k = 0;
    while (clk_out !== 1'b1 && k < budget) begin @(negedge clk); k++; end
    chk(nm, clk_out, 1'b1);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k = 0;
    while (running !== 1'b0 && k < budget) begin @(negedge clk); k++; end
    chk(nm, running, 1'b0);
  endtask

  task automatic offer(input int h, input int l, input int p);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_high  = W'(h);
    cfg_if.cfg_low   = W'(l);
    cfg_if.cfg_phase = W'(p);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_high = '0; cfg_if.cfg_low = '0; cfg_if.cfg_phase = '0;
    step(2);
    chk("reset clk_out", clk_out, 1'b0);
    chk("reset running", running, 1'b0);
    chk("reset cfg_ready", cfg_if.cfg_ready, 1'b1);

    // Defaults 1/1, phase 0: rises one cycle after enable.
    rst = 1'b0; enable = 1'b1;
    step(1); chk("default rise", clk_out, 1'b1);
    step(1); chk("default low", clk_out, 1'b0); chk("default tick", period_tick, 1'b1);
    step(1); chk("default rise again", clk_out, 1'b1);
    step(5);
    enable = 1'b0;
    wait_idle(10, "stop default");

    // 3/5 with phase 4, enable in the same cycle as the config.
    offer(3, 5, 4); enable = 1'b1;
    step(1); cfg_if.cfg_valid = 1'b0;
    chk("phase cycle1", clk_out, 1'b0);
    for (int i = 2; i <= 4; i++) begin step(1); chk("phase delay", clk_out, 1'b0); end
    step(1); chk("phase rise at 5", clk_out, 1'b1);
    step(20);

    // Reconfigure to 2/2 mid-HIGH.
    wait_clk_high(20, "reach high 3/5");
    offer(2, 2, 0);
    step(1); cfg_if.cfg_valid = 1'b0;
    chk("ready low while pending", cfg_if.cfg_ready, 1'b0);
    step(30);

    // Rejected config.
    wait_clk_high(10, "reach high 2/2");
    offer(3, 0, 0);
    step(1); cfg_if.cfg_valid = 1'b0;
    chk("cfg_err pulse", cfg_err, 1'b1);
    step(1); chk("cfg_err single", cfg_err, 1'b0);
    step(10);

    // Back to 3/5, then drop enable mid-HIGH.
    offer(3, 5, 0);
    step(1); cfg_if.cfg_valid = 1'b0;
    step(25);
    wait_clk_high(20, "reach high before stop");
    enable = 1'b0;
    wait_idle(20, "stop after full period");
    chk("stopped clk_out", clk_out, 1'b0);

    // Drop enable during the start delay.
    offer(3, 5, 6); enable = 1'b1;
    step(1); cfg_if.cfg_valid = 1'b0;
    step(1); enable = 1'b0;
    step(1); chk("delay abort running", running, 1'b0); chk("delay abort clk", clk_out, 1'b0);
    step(3);

    // Reset mid-HIGH restores the 1/1 defaults.
    enable = 1'b1;
    wait_clk_high(20, "reach high before reset");
    rst = 1'b1;
    step(1); chk("reset mid-high clk", clk_out, 1'b0); chk("reset mid-high run", running, 1'b0);
    rst = 1'b0;
    step(1); chk("post-reset rise", clk_out, 1'b1);
    step(1); chk("post-reset tick", period_tick, 1'b1);
    step(4);
    enable = 1'b0;
    wait_idle(10, "stop post-reset");

    // Maximum counts on the 4-bit build.
    offer(15, 15, 15); enable = 1'b1;
    step(1); cfg_if.cfg_valid = 1'b0;
    chk("max delay start", clk_out, 1'b0);
    for (int i = 2; i <= 15; i++) begin step(1); chk("max delay", clk_out, 1'b0); end
    step(1); chk("max rise at 16", clk_out, 1'b1);
    step(45);
    enable = 1'b0;
    wait_idle(40, "stop max");
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
